psum_accumulator: RTL and testbench

//  Accumulates the per-cycle partial sums produced by the combinational adder-tree stage
//  (NUM_SUM products -> one DATA_WIDTH word) over a programmable number of passes.
//  A pass is typically one input-channel group or one kernel row.

---
 rtl/psum_accumulator.sv | 131 +++++++++++++
 tb/tb_psum_accumulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Sums unsigned partial sums from the adder tree over a programmable number
// of passes and hands one saturated result per job to the output buffer over
// a valid/ready stream.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no job; waiting for start
//   ACCUM | accepting partial sums, one per beat, until the pass count is met
//   OUT   | result presented on out_data/out_sat until the consumer takes it
module psum_accumulator #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_PASSES = 16,
   parameter int CNT_WIDTH  = $clog2(MAX_PASSES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  cfg_passes,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sat,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0]  MAX_P    = CNT_WIDTH'(MAX_PASSES);
   localparam logic [CNT_WIDTH-1:0]  ONE_P    = CNT_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

   state_t                state;
   logic [DATA_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [CNT_WIDTH-1:0]  passes;
   logic                  sat;

   logic [DATA_WIDTH:0]   sum;
   logic                  sum_sat;
   logic                  beat;
   logic                  last_beat;

   // A request of zero passes still consumes one beat; oversize requests clip
   // to the largest job the counter is sized for.
   function automatic logic [CNT_WIDTH-1:0] clamp_passes(input logic [CNT_WIDTH-1:0] req);
      if (req == '0)
         return ONE_P;
      else if (req > MAX_P)
         return MAX_P;
      else
         return req;
   endfunction

   // Wide add so the carry is visible; reaching all-ones counts as saturation.
   always_comb begin
      sum       = {1'b0, acc} + {1'b0, in_data};
      sum_sat   = (sum >= {1'b0, ALL_ONES});
      beat      = in_valid && (state == ACCUM);
      last_beat = (cnt == (passes - ONE_P));
   end

   // Control FSM with accumulator, pass counter and sticky saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         passes <= '0;
         sat    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  passes <= clamp_passes(cfg_passes);
                  acc    <= '0;
                  cnt    <= '0;
                  sat    <= 1'b0;
                  state  <= ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  if (sum_sat) begin
                     acc <= ALL_ONES;
                     sat <= 1'b1;
                  end else begin
                     acc <= sum[DATA_WIDTH-1:0];
                  end
                  cnt <= cnt + ONE_P;
                  if (last_beat)
                     state <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (start) begin
                     // Back-to-back job: reload directly, no idle bubble.
                     passes <= clamp_passes(cfg_passes);
                     acc    <= '0;
                     cnt    <= '0;
                     sat    <= 1'b0;
                     state  <= ACCUM;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode from registered state/acc only; result is masked to zero
   // whenever it is not being offered.
   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == OUT);
      out_data  = (state == OUT) ? acc : '0;
      out_sat   = (state == OUT) ? sat : 1'b0;
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed jobs plus randomized jobs checked
// against a job-level model (saturating total of all beats of the job).
module tb_psum_accumulator;

   localparam int DW   = 16;
   localparam int MAXP = 16;
   localparam int CW   = $clog2(MAXP + 1);
   localparam int ONES = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] cfg_passes;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_sat;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] stim_q [$];
   bit            big;
   int unsigned   exp_data;
   int unsigned   exp_sat;

   psum_accumulator #(
      .DATA_WIDTH (DW),
      .MAX_PASSES (MAXP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_passes (cfg_passes),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int eff_passes(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > MAXP) return MAXP;
      return cfg;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_job(input int cfg);
      check_val("idle_in_ready", {31'b0, in_ready}, 32'd0);
      start      = 1'b1;
      cfg_passes = CW'(cfg);
      tick();
      start      = 1'b0;
      cfg_passes = CW'($urandom);
      check_val("start_busy", {31'b0, busy}, 32'd1);
      check_val("start_in_ready", {31'b0, in_ready}, 32'd1);
      check_val("start_out_valid", {31'b0, out_valid}, 32'd0);
   endtask

   // Feed one job's beats (with random idle gaps) and check the presented result.
   task automatic feed(input int cfg, input int gap_max);
      int unsigned   total;
      int            n;
      int            g;
      logic [DW-1:0] v;
      total = 0;
      n     = eff_passes(cfg);
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(0, gap_max);
         repeat (g) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            check_val("gap_in_ready", {31'b0, in_ready}, 32'd1);
            check_val("gap_out_valid", {31'b0, out_valid}, 32'd0);
            tick();
         end
         if (stim_q.size() > 0)
            v = stim_q.pop_front();
         else
            v = big ? DW'($urandom) : DW'($urandom_range(0, 16'h07FF));
         total += int'(v);
         in_valid = 1'b1;
         in_data  = v;
         check_val("beat_out_valid", {31'b0, out_valid}, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      exp_sat  = (total >= ONES) ? 1 : 0;
      exp_data = exp_sat ? ONES : total;
      check_val("res_out_valid", {31'b0, out_valid}, 32'd1);
      check_val("res_out_data", {16'b0, out_data}, exp_data);
      check_val("res_out_sat", {31'b0, out_sat}, exp_sat);
      check_val("res_in_ready", {31'b0, in_ready}, 32'd0);
   endtask

   // Stall the consumer, then hand off; optionally start the next job on the handshake.
   task automatic finish(input int rdy_dly, input bit nxt, input int ncfg);
      repeat (rdy_dly) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = DW'($urandom);
         start     = 1'($urandom);
         cfg_passes = CW'($urandom);
         tick();
         check_val("hold_out_valid", {31'b0, out_valid}, 32'd1);
         check_val("hold_out_data", {16'b0, out_data}, exp_data);
         check_val("hold_out_sat", {31'b0, out_sat}, exp_sat);
         check_val("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      start      = nxt;
      cfg_passes = CW'(ncfg);
      tick();
      out_ready  = 1'b0;
      start      = 1'b0;
      check_val("post_out_valid", {31'b0, out_valid}, 32'd0);
      check_val("post_out_data", {16'b0, out_data}, 32'd0);
      check_val("post_busy", {31'b0, busy}, {31'b0, nxt});
      check_val("post_in_ready", {31'b0, in_ready}, {31'b0, nxt});
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      check_val({tag, "_out_data"}, {16'b0, out_data}, 32'd0);
      check_val({tag, "_out_sat"}, {31'b0, out_sat}, 32'd0);
      check_val({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
   endtask

   initial begin
      int  cfg;
      int  ncfg;
      bit  nxt;
      bit  chained;
      rst_n      = 1'b0;
      start      = 1'b0;
      cfg_passes = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      big        = 1'b0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // 1: four back-to-back beats, result valid for exactly one cycle
      stim_q = '{16'd10, 16'd20, 16'd30, 16'd40};
      begin_job(4);
      feed(4, 0);
      check_val("t1_data", {16'b0, out_data}, 32'd100);
      finish(0, 1'b0, 0);

      // 2: saturation at second beat stays saturated
      stim_q = '{16'hF000, 16'h1000, 16'h0005};
      begin_job(3);
      feed(3, 0);
      check_val("t2_data", {16'b0, out_data}, 32'hFFFF);
      check_val("t2_sat", {31'b0, out_sat}, 32'd1);
      finish(0, 1'b0, 0);

      // 3: input gaps and consumer back-pressure
      stim_q = '{16'd1234, 16'd4321};
      begin_job(2);
      feed(2, 3);
      finish(5, 1'b0, 0);

      // 4: pass count clamping at both ends
      stim_q = '{16'd777};
      begin_job(0);
      feed(0, 0);
      check_val("t4_zero_data", {16'b0, out_data}, 32'd777);
      finish(1, 1'b0, 0);
      begin_job(MAXP + 5);
      feed(MAXP + 5, 1);
      finish(2, 1'b0, 0);

      // 5: restart on handshake; first beat of new job not added to old result
      stim_q = '{16'd500, 16'd600};
      begin_job(2);
      feed(2, 0);
      finish(1, 1'b1, 3);
      stim_q = '{16'd1, 16'd2, 16'd3};
      feed(3, 0);
      check_val("t5_data", {16'b0, out_data}, 32'd6);
      finish(0, 1'b0, 0);

      // 6: reset mid-accumulation, then a clean job
      begin_job(4);
      in_valid = 1'b1; in_data = 16'd100; tick();
      in_valid = 1'b1; in_data = 16'd200; tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_accum");
      tick();
      #3 rst_n = 1'b1;
      tick();
      stim_q = '{16'd1, 16'd2, 16'd3, 16'd4};
      begin_job(4);
      feed(4, 0);
      check_val("t6_clean", {16'b0, out_data}, 32'd10);
      // reset while a result is being offered drops it at once
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_out");
      tick();
      #3 rst_n = 1'b1;
      tick();
      check_all_zero("after_rst");

      // randomized jobs, some chained back-to-back
      chained = 1'b0;
      cfg     = 0;
      for (int j = 0; j < 30; j++) begin
         big = ($urandom_range(0, 2) == 0);
         if (!chained) begin
            cfg = $urandom_range(0, MAXP + 5);
            begin_job(cfg);
         end
         feed(cfg, $urandom_range(0, 2));
         ncfg = $urandom_range(0, MAXP + 5);
         nxt  = 1'($urandom);
         finish($urandom_range(0, 3), nxt, ncfg);
         chained = nxt;
         cfg     = ncfg;
      end
      if (chained) begin
         feed(cfg, 0);
         finish(0, 1'b0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
